// File: rtl/mac_axi_pkg.sv
// mac_axi_pkg: shared TX state enum, AXI address map, response codes and EOP byte-enable helper
package mac_axi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} tx_state_e;
  localparam logic [31:0] CTRL_OFFSET = 32'h0000_0800;
  localparam logic [31:0] BUF_LIMIT   = 32'h0000_07FC;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  // EOP word carries LEN[1:0] valid bytes (00 meaning 4); the MAC encodes that count minus one
  function automatic logic [1:0] len_to_be(input logic [1:0] l);
    return l - 2'd1;
  endfunction
endpackage

// File: rtl/tx_pkt_ram.sv
// tx_pkt_ram: simple dual-port packet RAM, byte-write port A, registered read port B
//   clk_i             clock
//   we_a_i/addr_a_i/din_a_i  byte-enabled write port
//   addr_b_i/dout_b_o         read port, data one cycle after address
module tx_pkt_ram #(
  parameter int AW = 9,
  parameter int DW = 32
)(
  input  logic            clk_i,
  input  logic [DW/8-1:0] we_a_i,
  input  logic [AW-1:0]   addr_a_i,
  input  logic [DW-1:0]   din_a_i,
  input  logic [AW-1:0]   addr_b_i,
  output logic [DW-1:0]   dout_b_o
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DW/8; b++)
      if (we_a_i[b]) mem[addr_a_i][8*b +: 8] <= din_a_i[8*b +: 8];
    dout_b_o <= mem[addr_b_i];
  end
endmodule

// File: rtl/axi_to_mac_tx_buffer.sv
// axi_to_mac_tx_buffer: AXI4-Lite write-only packet buffer drained to a MAC TX interface
//   mac_clk_i, ARESETN       clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*          AXI4-Lite write channels (buffer at 0x000-0x7FC, CTRL at 0x800)
//   tx_wa_i                  MAC write-available
//   tx_wr_o/data/be/sop/eop  registered TX word stream
//   tx_busy_o, tx_pkt_cnt_o  packet in flight, packets sent
module axi_to_mac_tx_buffer
  import mac_axi_pkg::*;
#(
  parameter int ADDR_W_MEM         = 9,
  parameter int DAT_W              = 32,
  parameter int BEN_W              = 2,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
)(
  input  logic                            mac_clk_i,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic                            tx_wa_i,
  output logic                            tx_wr_o,
  output logic [DAT_W-1:0]                tx_data_o,
  output logic [BEN_W-1:0]                tx_be_o,
  output logic                            tx_sop_o,
  output logic                            tx_eop_o,
  output logic                            tx_busy_o,
  output logic [31:0]                     tx_pkt_cnt_o
);
  tx_state_e state_q, state_d;
  logic awready_q, bvalid_q, busy_q;
  logic [1:0] bresp_q, resp;
  logic [11:0] len_q, idx_q, idx_d, cnt, wlen;
  logic tx_wr_q, tx_sop_q, tx_eop_q;
  logic [DAT_W-1:0] tx_data_q;
  logic [BEN_W-1:0] tx_be_q;
  logic [31:0] pkt_cnt_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic [ADDR_W_MEM-1:0] rd_addr;
  logic hs, is_buf, is_ctrl, start_ok, start, iss, last, is_last;
  logic unused;
  assign unused = ^S_AXI_AWPROT;
  // Address/data are held by the master while AWREADY is up, so the handshake cycle owns the decode
  assign hs       = awready_q;
  assign is_buf   = S_AXI_AWADDR <= BUF_LIMIT[C_S_AXI_ADDR_WIDTH-1:0];
  assign is_ctrl  = S_AXI_AWADDR == CTRL_OFFSET[C_S_AXI_ADDR_WIDTH-1:0];
  assign wlen     = S_AXI_WDATA[11:0];
  assign start_ok = is_ctrl && S_AXI_WDATA[31] && wlen != 12'd0 && wlen <= 12'd2048 && !busy_q;
  assign start    = hs && start_ok;
  assign resp     = ((is_buf && !busy_q) || (is_ctrl && (!S_AXI_WDATA[31] || start_ok))) ? RESP_OKAY : RESP_SLVERR;
  tx_pkt_ram #(.AW(ADDR_W_MEM), .DW(C_S_AXI_DATA_WIDTH)) u_ram (
    .clk_i   (mac_clk_i),
    .we_a_i  ((hs && is_buf && !busy_q) ? S_AXI_WSTRB : '0),
    .addr_a_i(S_AXI_AWADDR[ADDR_W_MEM+1:2]),
    .din_a_i (S_AXI_WDATA),
    .addr_b_i(rd_addr),
    .dout_b_o(rd_data)
  );
  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      if (hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= resp;
      end else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end
  always_ff @(posedge mac_clk_i)
    state_q <= !ARESETN ? ST_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // rd_data always holds word idx_q; the read address runs ahead by one whenever a word is issued
  always_comb begin
    cnt     = (len_q + 12'd3) >> 2;
    is_last = idx_q == cnt - 12'd1;
    last    = tx_wr_q && tx_eop_q;
    iss     = tx_wa_i && (state_q == ST_LOAD || (state_q == ST_SEND && !last));
    idx_d   = iss ? idx_q + 12'd1 : idx_q;
    rd_addr = idx_d[ADDR_W_MEM-1:0];
  end
  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      tx_wr_q   <= 1'b0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_be_q   <= 2'b11;
      tx_data_q <= '0;
      pkt_cnt_q <= '0;
      busy_q    <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      tx_wr_q <= iss;
      if (iss) begin
        tx_data_q <= rd_data;
        tx_sop_q  <= idx_q == 12'd0;
        tx_eop_q  <= is_last;
        tx_be_q   <= is_last ? len_to_be(len_q[1:0]) : 2'b11;
      end
      if (iss && is_last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      idx_q <= state_q == ST_DONE ? 12'd0 : idx_d;
      if (start) begin
        len_q  <= wlen;
        busy_q <= 1'b1;
      end else if (state_q == ST_DONE) busy_q <= 1'b0;
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign tx_wr_o       = tx_wr_q;
  assign tx_data_o     = tx_data_q;
  assign tx_be_o       = tx_be_q;
  assign tx_sop_o      = tx_sop_q;
  assign tx_eop_o      = tx_eop_q;
  assign tx_busy_o     = busy_q;
  assign tx_pkt_cnt_o  = pkt_cnt_q;
endmodule

// File: tb/tb_axi_to_mac_tx_buffer.sv
// tb_axi_to_mac_tx_buffer: scoreboard bench with a byte-array buffer model and random TX back-pressure
module tb_axi_to_mac_tx_buffer;
  typedef struct packed {logic [31:0] d; logic s; logic e; logic [1:0] b;} wexp_t;
  logic clk = 1'b0;
  logic ARESETN;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA;
  logic [2:0] S_AXI_AWPROT;
  logic [3:0] S_AXI_WSTRB;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0] S_AXI_BRESP;
  logic S_AXI_BVALID, S_AXI_BREADY;
  logic tx_wa_i = 1'b1;
  logic tx_wr_o, tx_sop_o, tx_eop_o, tx_busy_o;
  logic [31:0] tx_data_o, tx_pkt_cnt_o;
  logic [1:0] tx_be_o;
  int errs = 0, chks = 0, cyc = 0, exp_pkts = 0, eop_cyc = 0, words_seen = 0, wa_mode = 0;
  bit in_rst = 1'b0, busy_p = 1'b0;
  logic wa_s = 1'b1;
  byte unsigned mdl [2048];
  wexp_t q [$];
  wexp_t mon_e;
  always #5 clk = ~clk;
  axi_to_mac_tx_buffer dut (
    .mac_clk_i(clk), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .tx_wa_i(tx_wa_i), .tx_wr_o(tx_wr_o), .tx_data_o(tx_data_o), .tx_be_o(tx_be_o),
    .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .tx_busy_o(tx_busy_o), .tx_pkt_cnt_o(tx_pkt_cnt_o)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wa_s <= tx_wa_i;
  end
  always @(negedge clk)
    tx_wa_i = (wa_mode == 0) ? 1'b1 : (wa_mode == 1) ? ($urandom_range(0, 3) != 0) : !((cyc % 12) >= 6 && (cyc % 12) <= 10);
  always @(negedge clk) begin
    if (ARESETN && tx_wr_o) begin
      chk("word_only_after_wa_high", wa_s, 1'b1);
      if (q.size() == 0) chk("unexpected_tx_word", 1'b1, 1'b0);
      else begin
        mon_e = q.pop_front();
        chk("tx_word{data,sop,eop,be}", {tx_data_o, tx_sop_o, tx_eop_o, tx_be_o}, mon_e);
      end
      words_seen++;
      if (tx_eop_o) eop_cyc = cyc;
    end
    if (busy_p && !tx_busy_o && !in_rst) chk("busy_clear_cycles_after_eop", cyc - eop_cyc, 2);
    busy_p = tx_busy_o;
  end
  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bdly, output logic [1:0] r);
    int n;
    r = 2'bxx;
    @(negedge clk);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!S_AXI_AWREADY) begin
      chk("awready_timeout", 1'b0, 1'b1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    chk("wready_with_awready", S_AXI_WREADY, 1'b1);
    @(negedge clk);
    if (bdly == 0) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
    chk("bvalid_up_awready_down", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
    r = S_AXI_BRESP;
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_held_no_accept", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_BRESP}, {1'b1, 1'b0, r});
    end
    S_AXI_BREADY = 1'b1; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_cleared", S_AXI_BVALID, 1'b0);
  endtask
  task automatic load_words(input int n);
    logic [31:0] d;
    logic [3:0] s;
    logic [1:0] r;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      axi_wr(4 * i, d, 4'hF, 0, r);
      chk("buf_write_okay", r, 2'b00);
      for (int b = 0; b < 4; b++) mdl[4*i+b] = d[8*b +: 8];
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(1, 14));
        axi_wr(4 * i, d, s, 0, r);
        chk("buf_partial_write_okay", r, 2'b00);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[4*i+b] = d[8*b +: 8];
      end
    end
  endtask
  task automatic start_pkt(input int len);
    int nw, nb;
    logic [1:0] r;
    nw = (len + 3) / 4;
    nb = (len - 1) % 4 + 1;
    for (int i = 0; i < nw; i++)
      q.push_back(wexp_t'{d: {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]}, s: (i == 0), e: (i == nw - 1),
                          b: (i == nw - 1) ? 2'(nb - 1) : 2'b11});
    axi_wr(32'h800, 32'h8000_0000 | 32'(len), 4'hF, 0, r);
    chk("start_okay", r, 2'b00);
    exp_pkts++;
    chk("busy_after_start", tx_busy_o, 1'b1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy_o && n < 30000) begin @(negedge clk); n++; end
    chk("busy_clear_timeout", tx_busy_o, 1'b0);
    chk("all_words_sent", q.size(), 0);
    chk("pkt_cnt", tx_pkt_cnt_o, exp_pkts);
  endtask
  initial begin
    logic [1:0] r;
    logic [31:0] d;
    int len, w0, n;
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_axi{awready,wready,bvalid,bresp}", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP}, 5'b0);
    chk("rst_tx{wr,sop,eop,busy}", {tx_wr_o, tx_sop_o, tx_eop_o, tx_busy_o}, 4'b0);
    chk("rst_be", tx_be_o, 2'b11);
    chk("rst_data", tx_data_o, 32'h0);
    chk("rst_pkt_cnt", tx_pkt_cnt_o, 32'h0);
    ARESETN = 1'b1;
    wa_mode = 0;
    axi_wr(32'h0, 32'h1122_3344, 4'hF, 0, r);
    chk("word0_write_okay", r, 2'b00);
    d = 32'h1122_3344;
    for (int b = 0; b < 4; b++) mdl[b] = d[8*b +: 8];
    start_pkt(4);
    wait_idle();
    load_words(3);
    start_pkt(9);
    wait_idle();
    wa_mode = 2;
    load_words(50);
    start_pkt(200);
    wait_idle();
    wa_mode = 1;
    repeat (3) begin
      len = $urandom_range(1, 300);
      load_words((len + 3) / 4);
      start_pkt(len);
      wait_idle();
    end
    load_words(100);
    start_pkt(399);
    axi_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 0, r);
    chk("buf_write_while_busy_slverr", r, 2'b10);
    axi_wr(32'h800, 32'h8000_0004, 4'hF, 0, r);
    chk("start_while_busy_slverr", r, 2'b10);
    wait_idle();
    axi_wr(32'h800, 32'h8000_0000, 4'hF, 0, r);
    chk("start_len0_slverr", r, 2'b10);
    axi_wr(32'h800, 32'h8000_0801, 4'hF, 0, r);
    chk("start_len2049_slverr", r, 2'b10);
    axi_wr(32'h900, 32'h1234_5678, 4'hF, 0, r);
    chk("unmapped_0x900_slverr", r, 2'b10);
    axi_wr(32'h800, 32'h0000_0005, 4'hF, 0, r);
    chk("ctrl_start0_okay", r, 2'b00);
    chk("ctrl_start0_not_busy", tx_busy_o, 1'b0);
    start_pkt(399);
    wait_idle();
    d = $urandom;
    axi_wr(32'h20, d, 4'hF, 10, r);
    chk("bready_delay_write_okay", r, 2'b00);
    wa_mode = 0;
    load_words(512);
    for (int b = 0; b < 4; b++) mdl[32+b] = mdl[32+b];
    start_pkt(2048);
    w0 = words_seen;
    n = 0;
    while (words_seen < w0 + 20 && n < 300) begin @(negedge clk); n++; end
    chk("words_before_reset", words_seen >= w0 + 20, 1'b1);
    in_rst = 1'b1;
    ARESETN = 1'b0;
    @(negedge clk);
    chk("send_rst_tx{wr,sop,eop,busy}", {tx_wr_o, tx_sop_o, tx_eop_o, tx_busy_o}, 4'b0);
    chk("send_rst_be_data", {tx_be_o, tx_data_o}, {2'b11, 32'h0});
    chk("send_rst_pkt_cnt", tx_pkt_cnt_o, 32'h0);
    chk("send_rst_axi{awready,bvalid,bresp}", {S_AXI_AWREADY, S_AXI_BVALID, S_AXI_BRESP}, 4'b0);
    q.delete();
    exp_pkts = 0;
    ARESETN = 1'b1;
    @(negedge clk);
    in_rst = 1'b0;
    start_pkt(2048);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
